// File: rtl/id_scoreboard_pkg.sv
// Shared constants for the decode-stage register scoreboard.
package id_scoreboard_pkg;

    // Stall reason encodings reported to ctrl.
    localparam logic [1:0] STALL_NONE = 2'b00;
    localparam logic [1:0] STALL_RAW1 = 2'b01;
    localparam logic [1:0] STALL_RAW2 = 2'b10;
    localparam logic [1:0] STALL_WAW  = 2'b11;

    // Producer latencies, counted in stall cycles a dependent must wait.
    localparam int unsigned LAT_ALU  = 0;
    localparam int unsigned LAT_LOAD = 1;
    localparam int unsigned LAT_MUL  = 2;
    localparam int unsigned LAT_DIV  = 33;

    // Existing decode constants.
    localparam int unsigned ZERO_REG     = 0;
    localparam logic        READ_ENABLE  = 1'b1;
    localparam logic        WRITE_ENABLE = 1'b1;

endpackage

// File: rtl/id_scoreboard_sb_entry.sv
// One scoreboard entry: countdown of the cycles until its register is safe to use.
module id_scoreboard_sb_entry #(
    parameter int unsigned LAT_WIDTH = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 hold_i,
    input  logic                 load_i,
    input  logic [LAT_WIDTH-1:0] lat_i,
    output logic                 busy_o,
    output logic                 busy_d_o
);

    logic [LAT_WIDTH-1:0] cnt_q;
    logic [LAT_WIDTH-1:0] cnt_d;

    // Next count: freeze on hold, a new load wins over the decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (!hold_i) begin
            if (load_i) begin
                cnt_d = lat_i;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Countdown register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o   = (cnt_q != '0);
    assign busy_d_o = (cnt_d != '0);

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard: per-register latency tracking, RAW and WAW stall requests.
module id_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int unsigned REG_NUM     = 32,
    parameter int unsigned RADDR_WIDTH = 5,
    parameter int unsigned LAT_WIDTH   = 6,
    parameter int unsigned CNT_WIDTH   = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [RADDR_WIDTH-1:0] src1_raddr_i,
    input  logic                   src1_re_i,
    input  logic [RADDR_WIDTH-1:0] src2_raddr_i,
    input  logic                   src2_re_i,
    input  logic                   issue_valid_i,
    input  logic                   issue_we_i,
    input  logic [RADDR_WIDTH-1:0] issue_rd_i,
    input  logic [LAT_WIDTH-1:0]   issue_lat_i,
    input  logic                   hold_i,
    input  logic                   flush_i,
    output logic                   stallreq_o,
    output logic [1:0]             stall_reason_o,
    output logic [CNT_WIDTH-1:0]   pending_cnt_o
);

    localparam int unsigned REG_SPACE = 2 ** RADDR_WIDTH;
    localparam logic [RADDR_WIDTH-1:0] ZERO_ADDR = RADDR_WIDTH'(ZERO_REG);

    if (REG_NUM > REG_SPACE || REG_NUM < 2) begin : gen_bad_reg_num
        $fatal(1, "id_scoreboard: REG_NUM must be in 2..2**RADDR_WIDTH");
    end
    if (REG_NUM - 1 >= 2 ** CNT_WIDTH) begin : gen_bad_cnt_width
        $fatal(1, "id_scoreboard: CNT_WIDTH cannot hold REG_NUM-1");
    end

    logic [REG_NUM-1:0]   busy;
    logic [REG_NUM-1:0]   busy_d;
    logic [REG_SPACE-1:0] busy_ext;
    logic                 raw1;
    logic                 raw2;
    logic                 waw;
    logic                 accept;
    logic [CNT_WIDTH-1:0] pending_d;
    logic [CNT_WIDTH-1:0] pending_q;

    // x0 has no entry and always reads as idle.
    assign busy[0]   = 1'b0;
    assign busy_d[0] = 1'b0;

    for (genvar r = 1; r < REG_NUM; r++) begin : gen_entry
        logic load;
        assign load = accept && (issue_rd_i == RADDR_WIDTH'(r));

        id_scoreboard_sb_entry #(
            .LAT_WIDTH (LAT_WIDTH)
        ) u_entry (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .hold_i   (hold_i),
            .load_i   (load),
            .lat_i    (issue_lat_i),
            .busy_o   (busy[r]),
            .busy_d_o (busy_d[r])
        );
    end

    // Widened so any encodable address can index without going out of range.
    assign busy_ext = REG_SPACE'(busy);

    // Hazard detection, stall request with reason priority raw1 > raw2 > waw, and allocation.
    always_comb begin
        raw1 = (src1_re_i == READ_ENABLE) && (src1_raddr_i != ZERO_ADDR) &&
               busy_ext[src1_raddr_i];
        raw2 = (src2_re_i == READ_ENABLE) && (src2_raddr_i != ZERO_ADDR) &&
               busy_ext[src2_raddr_i];
        waw  = (issue_we_i == WRITE_ENABLE) && (issue_rd_i != ZERO_ADDR) &&
               busy_ext[issue_rd_i];

        stallreq_o     = !rst_i && issue_valid_i && !flush_i && (raw1 || raw2 || waw);
        stall_reason_o = STALL_NONE;
        if (stallreq_o) begin
            if (raw1) begin
                stall_reason_o = STALL_RAW1;
            end else if (raw2) begin
                stall_reason_o = STALL_RAW2;
            end else begin
                stall_reason_o = STALL_WAW;
            end
        end

        accept = issue_valid_i && !flush_i && !hold_i && !stallreq_o &&
                 (issue_we_i == WRITE_ENABLE) && (issue_rd_i != ZERO_ADDR) &&
                 (issue_lat_i != '0);
    end

    // Popcount of the post-update table so the registered count tracks the entries exactly.
    always_comb begin
        pending_d = '0;
        for (int unsigned r = 1; r < REG_NUM; r++) begin
            pending_d = pending_d + CNT_WIDTH'(busy_d[r]);
        end
    end

    // Pending-count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_cnt_o = pending_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed self-checking bench for id_scoreboard.
module tb_id_scoreboard;

    logic       clk;
    logic       rst;
    logic [4:0] src1_raddr;
    logic       src1_re;
    logic [4:0] src2_raddr;
    logic       src2_re;
    logic       issue_valid;
    logic       issue_we;
    logic [4:0] issue_rd;
    logic [5:0] issue_lat;
    logic       hold;
    logic       flush;
    logic       stallreq;
    logic [1:0] stall_reason;
    logic [5:0] pending_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    id_scoreboard #(
        .REG_NUM     (32),
        .RADDR_WIDTH (5),
        .LAT_WIDTH   (6),
        .CNT_WIDTH   (6)
    ) u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .src1_raddr_i   (src1_raddr),
        .src1_re_i      (src1_re),
        .src2_raddr_i   (src2_raddr),
        .src2_re_i      (src2_re),
        .issue_valid_i  (issue_valid),
        .issue_we_i     (issue_we),
        .issue_rd_i     (issue_rd),
        .issue_lat_i    (issue_lat),
        .hold_i         (hold),
        .flush_i        (flush),
        .stallreq_o     (stallreq),
        .stall_reason_o (stall_reason),
        .pending_cnt_o  (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // {stallreq, reason}: 3'b101 raw1, 3'b110 raw2, 3'b111 waw.
    function automatic logic [31:0] sr();
        return {29'd0, stallreq, stall_reason};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [4:0] rd, input logic we, input logic [5:0] lat,
                       input logic [4:0] s1, input logic r1, input logic [4:0] s2,
                       input logic r2);
        issue_valid = 1'b1;
        issue_we    = we;
        issue_rd    = rd;
        issue_lat   = lat;
        src1_raddr  = s1;
        src1_re     = r1;
        src2_raddr  = s2;
        src2_re     = r2;
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_rd    = '0;
        issue_lat   = '0;
        src1_re     = 1'b0;
        src2_re     = 1'b0;
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        hold  = 1'b0;
        flush = 1'b0;
        src1_raddr = '0;
        src2_raddr = '0;
        idle();
        tick();
        tick();
        put(5'd3, 1'b1, 6'd0, 5'd1, 1'b1, 5'd2, 1'b1);
        check("reset_stall", sr(), 32'd0);
        check("reset_pending", {26'd0, pending_cnt}, 32'd0);
        rst = 1'b0;
        idle();
        tick();

        // Load-use single bubble.
        put(5'd5, 1'b1, 6'd1, 5'd1, 1'b1, 5'd2, 1'b1);
        check("s1_ld_nostall", sr(), 32'd0);
        tick();
        check("s1_pend1", {26'd0, pending_cnt}, 32'd1);
        put(5'd6, 1'b1, 6'd0, 5'd5, 1'b1, 5'd1, 1'b1);
        check("s1_raw1", sr(), 32'd5);
        tick();
        check("s1_released", sr(), 32'd0);
        check("s1_pend0", {26'd0, pending_cnt}, 32'd0);
        tick();
        idle();

        // Long DIV, consumer reads it as rs2.
        put(5'd7, 1'b1, 6'd33, 5'd1, 1'b1, 5'd2, 1'b1);
        tick();
        put(5'd8, 1'b1, 6'd0, 5'd1, 1'b1, 5'd7, 1'b1);
        check("s2_pend1", {26'd0, pending_cnt}, 32'd1);
        for (int k = 0; k < 33; k++) begin
            check("s2_raw2", sr(), 32'd6);
            tick();
        end
        check("s2_released", sr(), 32'd0);
        check("s2_pend0", {26'd0, pending_cnt}, 32'd0);
        tick();
        // Unrelated instructions beside a DIV; only lat>0 entries count.
        put(5'd7, 1'b1, 6'd5, 5'd1, 1'b1, 5'd2, 1'b1);
        tick();
        put(5'd3, 1'b1, 6'd2, 5'd1, 1'b1, 5'd2, 1'b1);
        check("s2_mul_nostall", sr(), 32'd0);
        tick();
        check("s2_pend2a", {26'd0, pending_cnt}, 32'd2);
        put(5'd11, 1'b1, 6'd0, 5'd1, 1'b1, 5'd2, 1'b1);
        check("s2_alu_nostall", sr(), 32'd0);
        tick();
        check("s2_pend2b", {26'd0, pending_cnt}, 32'd2);
        idle();
        tick();
        check("s2_pend1b", {26'd0, pending_cnt}, 32'd1);
        tick();
        tick();
        check("s2_pend0b", {26'd0, pending_cnt}, 32'd0);

        // WAW: DIV x7 lat 10, LW x7 three cycles later waits 8 cycles.
        put(5'd7, 1'b1, 6'd10, 5'd1, 1'b1, 5'd2, 1'b1);
        tick();
        idle();
        tick();
        tick();
        put(5'd7, 1'b1, 6'd1, 5'd1, 1'b1, 5'd2, 1'b1);
        for (int k = 0; k < 8; k++) begin
            check("s3_waw", sr(), 32'd7);
            tick();
        end
        check("s3_ld_accept", sr(), 32'd0);
        tick();
        check("s3_pend1", {26'd0, pending_cnt}, 32'd1);
        put(5'd14, 1'b1, 6'd0, 5'd7, 1'b1, 5'd2, 1'b1);
        check("s3_raw1", sr(), 32'd5);
        tick();
        check("s3_released", sr(), 32'd0);
        check("s3_pend0", {26'd0, pending_cnt}, 32'd0);
        tick();
        idle();

        // Hold freezes the countdown.
        put(5'd9, 1'b1, 6'd1, 5'd1, 1'b1, 5'd2, 1'b1);
        tick();
        hold = 1'b1;
        put(5'd15, 1'b1, 6'd0, 5'd9, 1'b1, 5'd2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check("s4_hold_stall", sr(), 32'd5);
            check("s4_hold_pend", {26'd0, pending_cnt}, 32'd1);
            tick();
        end
        hold = 1'b0;
        #1;
        check("s4_last_stall", sr(), 32'd5);
        tick();
        check("s4_released", sr(), 32'd0);
        check("s4_pend0", {26'd0, pending_cnt}, 32'd0);
        tick();
        idle();

        // x0 and flush never stall or allocate.
        put(5'd0, 1'b1, 6'd1, 5'd1, 1'b1, 5'd2, 1'b1);
        check("s5_ld_x0", sr(), 32'd0);
        tick();
        check("s5_x0_pend", {26'd0, pending_cnt}, 32'd0);
        put(5'd16, 1'b1, 6'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        check("s5_rd_x0", sr(), 32'd0);
        tick();
        flush = 1'b1;
        put(5'd13, 1'b1, 6'd2, 5'd1, 1'b1, 5'd2, 1'b1);
        check("s5_flush_ld", sr(), 32'd0);
        tick();
        idle();
        flush = 1'b0;
        check("s5_flush_noalloc", {26'd0, pending_cnt}, 32'd0);
        put(5'd12, 1'b1, 6'd3, 5'd1, 1'b1, 5'd2, 1'b1);
        tick();
        flush = 1'b1;
        put(5'd13, 1'b1, 6'd2, 5'd12, 1'b1, 5'd2, 1'b1);
        check("s5_flush_dep", sr(), 32'd0);
        tick();
        idle();
        flush = 1'b0;
        check("s5_flush_keep", {26'd0, pending_cnt}, 32'd1);
        tick();
        tick();
        check("s5_drain", {26'd0, pending_cnt}, 32'd0);

        // Reset mid-flight discards the entry.
        put(5'd4, 1'b1, 6'd20, 5'd1, 1'b1, 5'd2, 1'b1);
        tick();
        put(5'd17, 1'b1, 6'd0, 5'd4, 1'b1, 5'd2, 1'b1);
        check("s6_pre_stall", sr(), 32'd5);
        check("s6_pre_pend", {26'd0, pending_cnt}, 32'd1);
        rst = 1'b1;
        #1;
        check("s6_rst_forced", sr(), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("s6_pend0", {26'd0, pending_cnt}, 32'd0);
        check("s6_unstalled", sr(), 32'd0);
        tick();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
